// File: rtl/sap_pkg.sv
// Shared definitions for the program-memory loader: memory geometry and FSM encoding.
package sap_pkg;

  localparam int PROM_DEPTH = 16;
  localparam int PROM_AW    = 4;
  localparam int PROM_DW    = 8;

  // Loader FSM encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  // A session is in flight while bytes are being taken, written or read back
  function automatic logic is_busy(input state_e s);
    return (s == ST_LOAD) || (s == ST_WRITE) || (s == ST_VERIFY);
  endfunction

  // States in which a start pulse opens a new session
  function automatic logic accepts_start(input state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/sum8_acc.sv
// Modular accumulator: synchronous clear has priority over accumulate.
module sum8_acc
  import sap_pkg::*;
#(
  parameter int DW = PROM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [DW-1:0] add_i,
  output logic [DW-1:0] sum_o
);

  logic [DW-1:0] sum_q;
  logic [DW-1:0] sum_d;

  // Next sum: clear, add (wrapping mod 2^DW) or hold
  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = sum_q + add_i;
    end
  end

  // Sum register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/prom16_loader.sv
// Program-loader front end: takes DEPTH bytes over valid/ready, writes them into the
// program memory, reads everything back and grants the memory to the CPU only when the
// read-back checksum matches the written one.
//
//  state  | meaning
//  IDLE   | after reset; memory untouched, waiting for start
//  LOAD   | byte_ready high, waiting for the next byte
//  WRITE  | one-cycle write strobe for the accepted byte
//  VERIFY | DEPTH+1 cycles: read addresses 0..DEPTH-1, then compare sums
//  DONE   | checksum matched; memory released to the CPU
//  ERROR  | checksum mismatch
module prom16_loader
  import sap_pkg::*;
#(
  parameter int DEPTH = PROM_DEPTH,
  parameter int AW    = PROM_AW,
  parameter int DW    = PROM_DW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [DW-1:0] byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic [DW-1:0] prom_data,
  output logic [AW-1:0] prom_addr,
  output logic          prom_low_load,
  output logic          prom_low_o_en,
  input  logic [DW-1:0] prom_rd_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_grant
);

  localparam int            PTR_LAST_I  = DEPTH - 1;
  localparam logic [AW-1:0] PTR_LAST    = PTR_LAST_I[AW-1:0];
  // The verify counter needs one extra bit: it runs 0..DEPTH, the last step being the compare
  localparam logic [AW:0]   VCNT_LAST   = DEPTH[AW:0];
  localparam logic [AW:0]   VCNT_PENULT = VCNT_LAST - 1'b1;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   vcnt_q, vcnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          ld_n_q, ld_n_d;
  logic          oe_n_q, oe_n_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          sum_clr;
  logic          wsum_en;
  logic          rsum_en;
  logic [DW-1:0] wsum;
  logic [DW-1:0] rsum;

  // Checksum of the bytes accepted from the programmer
  sum8_acc #(.DW(DW)) u_wsum (
    .clk   (clk),
    .rst   (clr),
    .clr_i (sum_clr),
    .en_i  (wsum_en),
    .add_i (data_d),
    .sum_o (wsum)
  );

  // Checksum of the bytes read back from the memory
  sum8_acc #(.DW(DW)) u_rsum (
    .clk   (clk),
    .rst   (clr),
    .clr_i (sum_clr),
    .en_i  (rsum_en),
    .add_i (prom_rd_data),
    .sum_o (rsum)
  );

  // Next state, pointers and memory-side controls; strobes default to inactive
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    vcnt_d  = vcnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ld_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    sum_clr = 1'b0;
    wsum_en = 1'b0;
    rsum_en = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start && accepts_start(state_q)) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          vcnt_d  = '0;
          sum_clr = 1'b1;
        end
      end

      ST_LOAD: begin
        if (byte_valid && ready_q) begin
          addr_d  = ptr_q;
          data_d  = byte_in;
          ld_n_d  = 1'b0;
          wsum_en = 1'b1;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        // The memory captures the byte on the edge that leaves this state
        if (ptr_q == PTR_LAST) begin
          ptr_d   = '0;
          vcnt_d  = '0;
          addr_d  = '0;
          oe_n_d  = 1'b0;
          state_d = ST_VERIFY;
        end else begin
          ptr_d   = ptr_q + 1'b1;
          state_d = ST_LOAD;
        end
      end

      ST_VERIFY: begin
        if (vcnt_q == VCNT_LAST) begin
          // All DEPTH read-backs are in rsum; release the read enable and decide
          state_d = (rsum == wsum) ? ST_DONE : ST_ERROR;
        end else begin
          // Read data is combinational from the address, so it is folded in on this edge
          oe_n_d  = 1'b0;
          rsum_en = 1'b1;
          vcnt_d  = vcnt_q + 1'b1;
          if (vcnt_q != VCNT_PENULT) begin
            addr_d = addr_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs are registered, so they are decoded from the upcoming state
  always_comb begin
    ready_d = (state_d == ST_LOAD);
    busy_d  = is_busy(state_d);
    done_d  = (state_d == ST_DONE);
    err_d   = (state_d == ST_ERROR);
  end

  // State and output registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      vcnt_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ld_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      vcnt_q  <= vcnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ld_n_q  <= ld_n_d;
      oe_n_q  <= oe_n_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign byte_ready    = ready_q;
  assign prom_data     = data_q;
  assign prom_addr     = addr_q;
  assign prom_low_load = ld_n_q;
  assign prom_low_o_en = oe_n_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign cpu_grant     = done_q;

endmodule
